// File: rtl/temp_monitor_mc.sv
// Multi-channel BCD temperature trend monitor (INIT/STABLE/RISE/FALL/STEADY/ERROR).
// Latency: a sample strobed at edge t reports done at edge t+2; one sample per cycle.
// No backpressure: every in-range sample is accepted and always produces one done pulse.
module temp_monitor_mc #(
  parameter int DIGITS     = 3,
  parameter int CHANNELS   = 4,
  parameter int CH_W       = 2,
  parameter int STABLE_CNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CH_W-1:0]       ch,
  input  logic [4*DIGITS-1:0]   temp_value,
  input  logic                  temp_value_sign,
  input  logic [4*DIGITS-1:0]   temp_delta,
  output logic                  done,
  output logic [CH_W-1:0]       done_ch,
  output logic [3:0]            state,
  output logic [4*CHANNELS-1:0] state_all
);

  // Binary magnitude fits in 4*DIGITS bits; one sign bit for values and two
  // extra bits for differences spanning +/-2*(10^DIGITS-1).
  localparam int MW = 4*DIGITS;
  localparam int VW = MW + 1;
  localparam int DW = MW + 2;
  localparam int CW = $clog2(STABLE_CNT + 1);

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam logic [MW-1:0] MAX_MAG = MW'(pow10(DIGITS) - 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CNT);

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_STABLE = 4'd1,
    ST_RISE   = 4'd2,
    ST_FALL   = 4'd3,
    ST_STEADY = 4'd4,
    ST_ERROR  = 4'd8
  } state_e;

  function automatic logic bcd_bad(input logic [MW-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic logic [MW-1:0] bcd2bin(input logic [MW-1:0] b);
    logic [MW-1:0] acc;
    acc = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc = acc * MW'(10) + MW'(b[4*i +: 4]);
    end
    return acc;
  endfunction

  // Per-channel storage
  logic signed [VW-1:0] old_q  [CHANNELS];
  logic                 seen_q [CHANNELS];
  logic [CW-1:0]        cnt_q  [CHANNELS];
  state_e               st_q   [CHANNELS];

  // Stage 1: decoded sample
  logic                 s1_vld_q;
  logic [CH_W-1:0]      s1_ch_q;
  logic signed [VW-1:0] s1_val_q;
  logic                 s1_err_q;
  logic [MW-1:0]        s1_dlt_q;

  // Stage 2: decoded sample plus channel history snapshot
  logic                 s2_vld_q;
  logic [CH_W-1:0]      s2_ch_q;
  logic signed [VW-1:0] s2_val_q;
  logic                 s2_err_q;
  logic [MW-1:0]        s2_dlt_q;
  logic signed [VW-1:0] s2_old_q;
  logic                 s2_seen_q;
  logic [CW-1:0]        s2_cnt_q;

  // Registered result
  logic                 done_q;
  logic [CH_W-1:0]      done_ch_q;
  state_e               state_q;

  // Input decode
  logic                 in_vld;
  logic [MW-1:0]        in_mag;
  logic signed [VW-1:0] in_mag_s;
  logic signed [VW-1:0] in_val;
  logic                 in_err;
  logic [MW-1:0]        in_dlt;

  // Decode BCD inputs; an illegal delta digit widens the band to the maximum.
  always_comb begin
    in_vld   = en && (32'(ch) < CHANNELS);
    in_mag   = bcd2bin(temp_value);
    in_err   = bcd_bad(temp_value);
    in_mag_s = $signed({1'b0, in_mag});
    in_val   = temp_value_sign ? -in_mag_s : in_mag_s;
    in_dlt   = bcd_bad(temp_delta) ? MAX_MAG : bcd2bin(temp_delta);
  end

  // Classification of the stage-2 sample and the channel history it leaves behind
  logic signed [DW-1:0] diff_d;
  logic [DW-1:0]        absd_d;
  logic [CW-1:0]        cnt_inc_d;
  logic signed [VW-1:0] old_d;
  logic                 seen_d;
  logic [CW-1:0]        cnt_d;
  state_e               st_d;

  // Compare against the snapshot; an errored sample leaves history untouched.
  always_comb begin
    diff_d    = DW'(s2_val_q) - DW'(s2_old_q);
    absd_d    = diff_d[DW-1] ? -diff_d : diff_d;
    cnt_inc_d = (s2_cnt_q == CNT_SAT) ? CNT_SAT : s2_cnt_q + CW'(1);
    old_d     = s2_old_q;
    seen_d    = s2_seen_q;
    cnt_d     = s2_cnt_q;
    st_d      = ST_ERROR;
    if (!s2_err_q) begin
      old_d  = s2_val_q;
      seen_d = 1'b1;
      if (!s2_seen_q) begin
        cnt_d = '0;
        st_d  = ST_STABLE;
      end else if (absd_d > {2'b00, s2_dlt_q}) begin
        cnt_d = '0;
        st_d  = diff_d[DW-1] ? ST_FALL : ST_RISE;
      end else begin
        cnt_d = cnt_inc_d;
        st_d  = (cnt_inc_d == CNT_SAT) ? ST_STEADY : ST_STABLE;
      end
    end
  end

  // Snapshot source: the history being written this cycle wins over storage
  // when the older sample targets the same channel.
  logic                 fwd_d;
  logic signed [VW-1:0] snap_old_d;
  logic                 snap_seen_d;
  logic [CW-1:0]        snap_cnt_d;

  always_comb begin
    fwd_d       = s2_vld_q && (s2_ch_q == s1_ch_q);
    snap_old_d  = fwd_d ? old_d  : old_q[s1_ch_q];
    snap_seen_d = fwd_d ? seen_d : seen_q[s1_ch_q];
    snap_cnt_d  = fwd_d ? cnt_d  : cnt_q[s1_ch_q];
  end

  // Pipeline registers; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld_q  <= 1'b0;
      s1_ch_q   <= '0;
      s1_val_q  <= '0;
      s1_err_q  <= 1'b0;
      s1_dlt_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_ch_q   <= '0;
      s2_val_q  <= '0;
      s2_err_q  <= 1'b0;
      s2_dlt_q  <= '0;
      s2_old_q  <= '0;
      s2_seen_q <= 1'b0;
      s2_cnt_q  <= '0;
    end else begin
      s1_vld_q  <= in_vld;
      s1_ch_q   <= ch;
      s1_val_q  <= in_val;
      s1_err_q  <= in_err;
      s1_dlt_q  <= in_dlt;
      s2_vld_q  <= s1_vld_q;
      s2_ch_q   <= s1_ch_q;
      s2_val_q  <= s1_val_q;
      s2_err_q  <= s1_err_q;
      s2_dlt_q  <= s1_dlt_q;
      s2_old_q  <= snap_old_d;
      s2_seen_q <= snap_seen_d;
      s2_cnt_q  <= snap_cnt_d;
    end
  end

  // Channel history update, only for the addressed channel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        old_q[k]  <= '0;
        seen_q[k] <= 1'b0;
        cnt_q[k]  <= '0;
        st_q[k]   <= ST_INIT;
      end
    end else if (s2_vld_q) begin
      old_q[s2_ch_q]  <= old_d;
      seen_q[s2_ch_q] <= seen_d;
      cnt_q[s2_ch_q]  <= cnt_d;
      st_q[s2_ch_q]   <= st_d;
    end
  end

  // Result pulse registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q    <= 1'b0;
      done_ch_q <= '0;
      state_q   <= ST_INIT;
    end else begin
      done_q    <= s2_vld_q;
      done_ch_q <= s2_ch_q;
      state_q   <= st_d;
    end
  end

  assign done    = done_q;
  assign done_ch = done_ch_q;
  assign state   = state_q;

  // Flatten per-channel states onto the status bus.
  always_comb begin
    state_all = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      state_all[4*k +: 4] = st_q[k];
    end
  end

endmodule

// File: tb/tb_temp_monitor_mc.sv
module tb_temp_monitor_mc;

  localparam int NCH  = 4;
  localparam int SCNT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  ch;
  logic [11:0] temp_value;
  logic        temp_value_sign;
  logic [11:0] temp_delta;
  logic        done;
  logic [1:0]  done_ch;
  logic [3:0]  state;
  logic [15:0] state_all;

  int checks = 0;
  int errors = 0;

  temp_monitor_mc #(.DIGITS(3), .CHANNELS(NCH), .CH_W(2), .STABLE_CNT(SCNT)) dut (
    .clk(clk), .rst(rst), .en(en), .ch(ch),
    .temp_value(temp_value), .temp_value_sign(temp_value_sign),
    .temp_delta(temp_delta), .done(done), .done_ch(done_ch),
    .state(state), .state_all(state_all)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel history as plain integers
  int  old_m  [NCH];
  bit  seen_m [NCH];
  int  cnt_m  [NCH];
  int  comm_m [NCH];   // state as visible on state_all after done
  bit  p0v, p1v;
  int  p0c, p1c, p0s, p1s;
  bit  exp_done;
  int  exp_ch, exp_st;
  logic [15:0] exp_all;
  int  prev_mag [NCH];

  function automatic bit bcd_bad(input logic [11:0] b);
    bit bad = 0;
    for (int i = 0; i < 3; i++) if (((b >> (4*i)) & 12'hF) > 9) bad = 1;
    return bad;
  endfunction

  function automatic int bcd_val(input logic [11:0] b);
    int v = 0;
    for (int i = 2; i >= 0; i--) v = v * 10 + int'((b >> (4*i)) & 12'hF);
    return v;
  endfunction

  function automatic logic [11:0] to_bcd(input int m);
    logic [11:0] r;
    r = 12'((m / 100) << 8) | 12'(((m / 10) % 10) << 4) | 12'(m % 10);
    return r;
  endfunction

  function automatic int model_apply(input int c, input logic [11:0] v, input bit s,
                                     input logic [11:0] dl);
    int nv, d, ad, dm;
    if (bcd_bad(v)) return 8;
    nv = s ? -bcd_val(v) : bcd_val(v);
    dm = bcd_bad(dl) ? 999 : bcd_val(dl);
    if (!seen_m[c]) begin
      seen_m[c] = 1; old_m[c] = nv; cnt_m[c] = 0;
      return 1;
    end
    d = nv - old_m[c];
    old_m[c] = nv;
    ad = (d < 0) ? -d : d;
    if (ad > dm) begin
      cnt_m[c] = 0;
      return (d > 0) ? 2 : 3;
    end
    cnt_m[c] = (cnt_m[c] + 1 > SCNT) ? SCNT : cnt_m[c] + 1;
    return (cnt_m[c] == SCNT) ? 4 : 1;
  endfunction

  // Drive one cycle, advance the model pipeline, settle 1 time unit past the edge.
  task automatic tick(input bit r, input bit e, input int c, input logic [11:0] v,
                      input bit s, input logic [11:0] dl);
    bit nv = 0;
    int ns = 0;
    rst = r; en = e; ch = c[1:0]; temp_value = v; temp_value_sign = s; temp_delta = dl;
    if (!r) begin
      for (int k = 0; k < NCH; k++) begin
        old_m[k] = 0; seen_m[k] = 0; cnt_m[k] = 0; comm_m[k] = 0;
      end
      p0v = 0; p1v = 0;
    end else if (e && c < NCH) begin
      ns = model_apply(c, v, s, dl);
      nv = 1;
    end
    @(posedge clk);
    exp_done = r ? p1v : 1'b0;
    exp_ch   = p1c;
    exp_st   = p1s;
    if (r) begin
      p1v = p0v; p1c = p0c; p1s = p0s;
      p0v = nv;  p0c = c;   p0s = ns;
    end
    if (exp_done) comm_m[exp_ch] = exp_st;
    exp_all = '0;
    for (int k = 0; k < NCH; k++) exp_all[4*k +: 4] = 4'(comm_m[k]);
    #1;
  endtask

  task automatic idle();
    tick(1, 0, 0, 12'h000, 0, 12'h000);
  endtask

  task automatic issue_wait(input int c, input logic [11:0] v, input bit s, input logic [11:0] dl);
    tick(1, 1, c, v, s, dl);
    idle();
    idle();
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 12'h000, 0, 12'h000);
    tick(0, 1, 1, 12'h123, 0, 12'h000);
    checks++;
    if (done !== 1'b0 || done_ch !== 2'd0 || state !== 4'd0 || state_all !== 16'h0000) begin
      errors++;
      $display("FAIL reset_init: done=%0b ch=%0d state=%0d all=%h want 0/0/0/0000",
               done, done_ch, state, state_all);
    end
    // reset in the middle of traffic discards in-flight samples
    tick(1, 1, 0, 12'h100, 0, 12'h010);
    tick(1, 1, 1, 12'h200, 0, 12'h010);
    tick(0, 1, 2, 12'h300, 0, 12'h010);
    checks++;
    if (done !== 1'b0 || state_all !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid: done=%0b all=%h want 0/0000", done, state_all);
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL reset_flush%0d: done=%0b want 0", i, done);
      end
    end
    issue_wait(2, 12'h300, 0, 12'h010);
    checks++;
    if (done !== 1'b1 || done_ch !== 2'd2 || state !== 4'd1 || state_all !== 16'h0100) begin
      errors++;
      $display("FAIL reset_seen: done=%0b ch=%0d state=%0d all=%h want 1/2/1/0100",
               done, done_ch, state, state_all);
    end
  endtask

  task automatic test_threshold();
    logic [11:0] vals [3];
    int          want [3];
    vals = '{12'h100, 12'h133, 12'h167};
    want = '{1, 1, 2};
    for (int i = 0; i < 3; i++) begin
      issue_wait(0, vals[i], 0, 12'h033);
      checks++;
      if (done !== 1'b1 || done_ch !== 2'd0 || state !== 4'(want[i])) begin
        errors++;
        $display("FAIL threshold%0d: done=%0b ch=%0d state=%0d want 1/0/%0d",
                 i, done, done_ch, state, want[i]);
      end
    end
  endtask

  task automatic test_sign();
    logic [11:0] vals [4];
    bit          sg   [4];
    int          want [4];
    vals = '{12'h010, 12'h025, 12'h000, 12'h000};
    sg   = '{0, 1, 0, 1};
    want = '{1, 3, 1, 1};
    for (int i = 0; i < 4; i++) begin
      issue_wait(1, vals[i], sg[i], 12'h030);
      checks++;
      if (done !== 1'b1 || done_ch !== 2'd1 || state !== 4'(want[i])) begin
        errors++;
        $display("FAIL sign%0d: done=%0b ch=%0d state=%0d want 1/1/%0d",
                 i, done, done_ch, state, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] vals [3];
    int          want [3];
    vals = '{12'h200, 12'h250, 12'h251};
    want = '{1, 2, 1};
    tick(0, 0, 0, 12'h000, 0, 12'h000);
    for (int i = 0; i < 3; i++) tick(1, 1, 2, vals[i], 0, 12'h010);
    checks++;
    if (done !== 1'b1 || done_ch !== 2'd2 || state !== 4'(want[0])) begin
      errors++;
      $display("FAIL fwd0: done=%0b ch=%0d state=%0d want 1/2/%0d", done, done_ch, state, want[0]);
    end
    for (int i = 1; i < 3; i++) begin
      idle();
      checks++;
      if (done !== 1'b1 || done_ch !== 2'd2 || state !== 4'(want[i])) begin
        errors++;
        $display("FAIL fwd%0d: done=%0b ch=%0d state=%0d want 1/2/%0d",
                 i, done, done_ch, state, want[i]);
      end
    end
    idle();
    checks++;
    if (done !== 1'b0 || state_all !== 16'h0100) begin
      errors++;
      $display("FAIL fwd_end: done=%0b all=%h want 0/0100", done, state_all);
    end
  endtask

  task automatic test_error();
    issue_wait(3, 12'h050, 0, 12'h010);
    issue_wait(3, 12'h0A5, 0, 12'h010);
    checks++;
    if (done !== 1'b1 || done_ch !== 2'd3 || state !== 4'd8 || state_all[15:12] !== 4'd8) begin
      errors++;
      $display("FAIL error_digit: done=%0b ch=%0d state=%0d ch3=%0d want 1/3/8/8",
               done, done_ch, state, state_all[15:12]);
    end
    issue_wait(3, 12'h055, 0, 12'h010);
    checks++;
    if (done !== 1'b1 || state !== 4'd1) begin
      errors++;
      $display("FAIL error_recover: done=%0b state=%0d want 1/1", done, state);
    end
    // illegal delta digits act as the widest band
    issue_wait(3, 12'h900, 0, 12'hF00);
    checks++;
    if (done !== 1'b1 || state !== 4'd1) begin
      errors++;
      $display("FAIL error_delta: done=%0b state=%0d want 1/1", done, state);
    end
  endtask

  task automatic test_steady();
    tick(0, 0, 0, 12'h000, 0, 12'h000);
    for (int i = 0; i < 5; i++) begin
      issue_wait(0, 12'h300, 0, 12'h001);
      checks++;
      if (done !== 1'b1 || state !== ((i < 4) ? 4'd1 : 4'd4)) begin
        errors++;
        $display("FAIL steady%0d: done=%0b state=%0d want 1/%0d", i, done, state, (i < 4) ? 1 : 4);
      end
    end
    issue_wait(0, 12'h310, 0, 12'h001);
    checks++;
    if (done !== 1'b1 || state !== 4'd2) begin
      errors++;
      $display("FAIL steady_rise: done=%0b state=%0d want 1/2", done, state);
    end
    issue_wait(0, 12'h310, 0, 12'h001);
    checks++;
    if (done !== 1'b1 || state !== 4'd1) begin
      errors++;
      $display("FAIL steady_cleared: done=%0b state=%0d want 1/1", done, state);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < NCH; k++) prev_mag[k] = 0;
    tick(0, 0, 0, 12'h000, 0, 12'h000);
    for (int n = 0; n < 600; n++) begin
      int c, m, r;
      bit e, s;
      logic [11:0] v, dl;
      c = $urandom_range(0, NCH - 1);
      e = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 60) begin
        m = prev_mag[c] + $urandom_range(0, 60) - 30;
        if (m < 0) m = -m;
        if (m > 999) m = 999;
      end else begin
        m = $urandom_range(0, 999);
      end
      if (e) prev_mag[c] = m;
      s  = ($urandom_range(0, 4) == 0);
      v  = to_bcd(m);
      if ($urandom_range(0, 19) == 0) v[7:4] = 4'($urandom_range(10, 15));
      dl = to_bcd($urandom_range(0, 40));
      if ($urandom_range(0, 19) == 0) dl[11:8] = 4'($urandom_range(10, 15));
      tick(($urandom_range(0, 99) != 0), e, c, v, s, dl);
      checks++;
      if (done !== exp_done || (exp_done && (done_ch !== 2'(exp_ch) || state !== 4'(exp_st)))
          || state_all !== exp_all) begin
        errors++;
        $display("FAIL random%0d: done=%0b ch=%0d state=%0d all=%h want %0b/%0d/%0d/%h",
                 n, done, done_ch, state, state_all, exp_done, exp_ch, exp_st, exp_all);
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; ch = '0; temp_value = '0; temp_value_sign = 1'b0; temp_delta = '0;
    p0v = 0; p1v = 0; p0c = 0; p1c = 0; p0s = 0; p1s = 0;
    #2;
    test_reset();
    tick(0, 0, 0, 12'h000, 0, 12'h000);
    test_threshold();
    test_sign();
    test_back_to_back();
    test_error();
    test_steady();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
